// File: rtl/spi8_pkg.sv
`timescale 1ns/1ps
// spi8_pkg: frame layout, FSM states and register map shared by the
// spi8 initiator and the remote spi8 register slave.
package spi8_pkg;

    // 16-bit frame: {rw, addr[6:0], data[7:0]}, transmitted MSB first
    localparam int FRAME_W  = 16;
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;

    // Initiator sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_TAIL  = 3'd4
    } spi_state_e;

    // Remote slave register map
    localparam logic [6:0] REG00 = 7'h00;
    localparam logic [6:0] REG01 = 7'h01;
    localparam logic [6:0] REG02 = 7'h02;
    localparam logic [6:0] REG03 = 7'h03;
    localparam logic [6:0] REG04 = 7'h04;
    localparam logic [6:0] REG05 = 7'h05;
    localparam logic [6:0] REG06 = 7'h06;
    localparam logic [6:0] REG07 = 7'h07;

    // Assemble a frame; the data field is forced to zero on reads
    function automatic logic [FRAME_W-1:0] build_frame(input logic       rw,
                                                       input logic [6:0] addr,
                                                       input logic [7:0] wdata);
        logic [FRAME_W-1:0] f;
        f                    = {FRAME_W{1'b0}};
        f[RW_BIT]            = rw;
        f[ADDR_MSB:ADDR_LSB] = addr;
        f[DATA_MSB:0]        = rw ? 8'h00 : wdata;
        return f;
    endfunction

endpackage

// File: rtl/spi8_clkgen.sv
`timescale 1ns/1ps
// spi8_clkgen: half-period tick generator. Every DIV enabled cycles it
// ends a half period, reporting whether that boundary is the end of a
// low phase (rise_tick) or a high phase (fall_tick). SCLK only rises when
// sclk_en is set, so the low-only phases (select setup, hold) reuse the
// same timebase. Disabled: counter cleared and SCLK parked low.
module spi8_clkgen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sclk_en,
    output logic rise_tick,
    output logic fall_tick,
    output logic sclk
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_r;
    logic          sclk_r;
    logic          wrap_s;

    assign wrap_s    = en && (cnt_r == CW'(DIV - 1));
    assign rise_tick = wrap_s && !sclk_r;
    assign fall_tick = wrap_s && sclk_r;
    assign sclk      = sclk_r;

    // Half-period counter and registered SCLK
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            sclk_r <= 1'b0;
        end else if (!en) begin
            cnt_r  <= {CW{1'b0}};
            sclk_r <= 1'b0;
        end else begin
            if (wrap_s) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
            if (rise_tick && sclk_en) begin
                sclk_r <= 1'b1;
            end else if (fall_tick) begin
                sclk_r <= 1'b0;
            end else begin
                sclk_r <= sclk_r;
            end
        end
    end

endmodule

// File: rtl/spi8_master.sv
`timescale 1ns/1ps
// spi8_master: SPI mode-0 initiator issuing one 16-bit frame per request
// to a remote spi8 register slave. Writes are followed by TAIL deselected
// SCLK pulses on which the slave commits the data.
module spi8_master
    import spi8_pkg::*;
#(
    parameter int DIV  = 4,
    parameter int TAIL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       SCLK,
    output logic       SV_n,
    output logic       SI,
    input  logic       SO
);

    localparam int TCW = (TAIL > 1) ? $clog2(TAIL) : 1;

    spi_state_e         state_r, state_s;
    logic [FRAME_W-1:0] frame_r, frame_s;
    logic               rw_r, rw_s;
    logic [4:0]         bit_r, bit_s;
    logic [TCW-1:0]     tail_r, tail_s;
    logic [7:0]         shadow_r, shadow_s;
    logic [7:0]         rdata_r, rdata_s;
    logic               sv_n_r, sv_n_s;
    logic               si_r, si_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;

    logic               clk_en_s;
    logic               sclk_en_s;
    logic               rise_tick_s;
    logic               fall_tick_s;
    logic               sclk_s;

    // The timebase starts once select is asserted (first SETUP cycle is
    // the select-assert cycle) and runs until the frame returns to idle.
    assign clk_en_s  = (state_r != ST_IDLE) && !((state_r == ST_SETUP) && sv_n_r);
    assign sclk_en_s = (state_r == ST_SHIFT) || (state_r == ST_TAIL);

    spi8_clkgen #(
        .DIV(DIV)
    ) u_clkgen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (clk_en_s),
        .sclk_en  (sclk_en_s),
        .rise_tick(rise_tick_s),
        .fall_tick(fall_tick_s),
        .sclk     (sclk_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Frame, counters, shadow and registered pad/handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_r  <= {FRAME_W{1'b0}};
            rw_r     <= 1'b0;
            bit_r    <= 5'd0;
            tail_r   <= {TCW{1'b0}};
            shadow_r <= 8'h00;
            rdata_r  <= 8'h00;
            sv_n_r   <= 1'b1;
            si_r     <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            frame_r  <= frame_s;
            rw_r     <= rw_s;
            bit_r    <= bit_s;
            tail_r   <= tail_s;
            shadow_r <= shadow_s;
            rdata_r  <= rdata_s;
            sv_n_r   <= sv_n_s;
            si_r     <= si_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    // Next-state and next-value logic; frame_r is shifted left so its
    // bit 14 is always the next bit to present on SI
    always_comb begin
        state_s  = state_r;
        frame_s  = frame_r;
        rw_s     = rw_r;
        bit_s    = bit_r;
        tail_s   = tail_r;
        shadow_s = shadow_r;
        rdata_s  = rdata_r;
        sv_n_s   = sv_n_r;
        si_s     = si_r;
        busy_s   = busy_r;
        done_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    frame_s = build_frame(rw, addr, wdata);
                    rw_s    = rw;
                    bit_s   = 5'd0;
                    tail_s  = {TCW{1'b0}};
                    busy_s  = 1'b1;
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (sv_n_r) begin
                    sv_n_s = 1'b0;
                    si_s   = frame_r[FRAME_W-1];
                end else if (rise_tick_s) begin
                    state_s = ST_SHIFT;
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_SHIFT: begin
                if (rise_tick_s) begin
                    // Only the data half of the frame carries slave output
                    if (bit_r >= 5'd8) begin
                        shadow_s = {shadow_r[6:0], SO};
                    end else begin
                        shadow_s = shadow_r;
                    end
                end else if (fall_tick_s) begin
                    if (bit_r == 5'd15) begin
                        sv_n_s  = 1'b1;
                        si_s    = 1'b0;
                        state_s = ST_HOLD;
                    end else begin
                        bit_s   = bit_r + 5'd1;
                        si_s    = frame_r[FRAME_W-2];
                        frame_s = {frame_r[FRAME_W-2:0], 1'b0};
                    end
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                if (rise_tick_s) begin
                    if (rw_r) begin
                        rdata_s = shadow_r;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_TAIL;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_TAIL: begin
                if (fall_tick_s) begin
                    if (tail_r == TCW'(TAIL - 1)) begin
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end else begin
                        tail_s = tail_r + TCW'(1);
                    end
                end else begin
                    state_s = ST_TAIL;
                end
            end
            default: begin
                sv_n_s  = 1'b1;
                si_s    = 1'b0;
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
        endcase
    end

    assign busy  = busy_r;
    assign done  = done_r;
    assign rdata = rdata_r;
    assign SCLK  = sclk_s;
    assign SV_n  = sv_n_r;
    assign SI    = si_r;

endmodule

// File: doc/spi8_master.md
Name: spi8_master

Overview:
- SPI initiator for the 8-bit register slave on the debug SPI pads. Drives SCLK, SV_n and SI; samples SO.
- Converts a core-side single-transaction request into one 16-bit frame, MSB first:
  - bit15 = r/w (1 = read)
  - bits14:8 = register address
  - bits7:0 = data (0x00 on reads)
- Sits in the bring-up/debug controller, so on-chip logic or a test host can program reg00..reg07 of a remote spi8 slave.

Parameters:
- DIV, 4, clk cycles per SCLK half-period; legal range is >= 2.
- TAIL, 2, SCLK pulses issued with SV_n high after a write frame; slave commits the write on these edges; legal range is >= 1.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request strobe; accepted only when busy=0
- rw  in  1  1 = read, 0 = write; latched on accept
- addr  in  7  register address; latched on accept
- wdata  in  8  write data; latched on accept, ignored for reads
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- rdata  out  8  read result; updated only at done of a read
- SCLK  out  1  SPI clock, mode 0, idles low
- SV_n  out  1  active-low slave select, idles high
- SI  out  1  serial data to slave, MSB first
- SO  in  1  serial data from slave

Behaviour:
- Reset (async, any state): SCLK=0, SV_n=1, SI=0, busy=0, done=0, rdata=0x00, FSM=IDLE, counters=0. Reset mid-frame aborts immediately with no further SCLK edges.
- FSM: IDLE -> SETUP -> SHIFT -> HOLD -> [TAIL, writes only] -> IDLE.
- IDLE:
  - Accept start: latch frame {rw, addr, rw ? 8'h00 : wdata}; busy=1 from next cycle.
  - On the next cycle, SV_n=0 and SI=frame[15].
- SETUP: SCLK low for DIV cycles (select setup).
- SHIFT: 16 bits. Each bit is SCLK low for DIV cycles, then high for DIV cycles.
  - SI changes only at bit start, while SCLK is low.
  - SO is sampled on the clk edge that drives SCLK high.
  - Bits 0..7 sampled are discarded; bits 8..15 are shifted MSB-first into a read shadow register.
- HOLD: SCLK low, SV_n=1, SI=0 for DIV cycles.
- TAIL (writes only): TAIL full SCLK periods (DIV low, DIV high) with SV_n=1.
- Done cycle:
  - Final cycle returns to IDLE: busy=0 and done=1 together.
  - For a read, rdata=shadow in that same cycle; for a write, rdata is unchanged.
  - A start in the done cycle is accepted (back-to-back).
- Latency from the edge accepting start to the edge asserting done:
  - read = 34*DIV+1 cycles (137 at defaults)
  - write = (34+2*TAIL)*DIV+1 cycles (153 at defaults)
- Simultaneous events:
  - start while busy=1 is ignored entirely, with no queueing.
  - rw/addr/wdata changes while busy have no effect.
- SO is treated as synchronous to the generated SCLK; no synchronizer is used, which is valid because DIV >= 2 gives a full half-period of settling.
- Counters:
  - Bit counter is 5 bits, 0..15, terminal at 15.
  - Divider counter is clog2(DIV) bits and wraps at DIV-1.
  - Tail counter counts 0..TAIL-1.
- Exactly 16 rising SCLK edges occur while SV_n=0, every frame.
- No glitches: SCLK, SV_n and SI are all registered outputs.

Decomposition:
- Package spi8_pkg:
  - frame field positions: RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8, DATA_MSB=7
  - FRAME_W=16
  - FSM state enum {IDLE, SETUP, SHIFT, HOLD, TAIL}
  - register address constants 0x00..0x07, shared with the slave
- One sub-module, spi8_clkgen:
  - DIV-parameterised half-period tick generator with enable.
  - Outputs rise_tick/fall_tick pulses and a registered SCLK.
  - Held idle-low when disabled.

Test Plan:
- Write addr 0x03, wdata 0xA5 -> SI shows 0x03A5 MSB first across 16 SCLK rises; 2 tail pulses with SV_n=1; behavioural slave model reg03=0xA5; done at cycle 153; rdata unchanged.
- Read addr 0x05, slave returns 0x3C -> SI frame 0x8500; SO sampled on rises 9..16; rdata=0x3C in the done cycle; no tail pulses; done at cycle 137.
- start pulsed at cycle 40 of an active write -> ignored; exactly one frame and one done pulse; latched addr/data unchanged.
- rst_n asserted mid-SHIFT at bit 6 -> same-time SCLK=0, SV_n=1, busy=0, rdata=0; after release, a new write to 0x07=0xFF completes normally.
- Back-to-back: write 0x00=0x00, start held high through done -> second read of 0x00 accepted in the done cycle; SV_n high for at least DIV+TAIL*2*DIV cycles between frames; rdata=0x00.
- DIV=2, TAIL=1 build: write addr 0x7F, 0x5A -> frame 0x7F5A; done at cycle (34+2)*2+1=73; SCLK high/low exactly 2 cycles each.
